alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle integer ALU in the MIPS-Lite execute stage. It executes MULT, MULTU, DIV and DIVU iteratively and owns the architectural HI/LO registers. It also handles the MTHI/MTLO writes. The controller starts an operation with a one-cycle strobe, stalls on `Busy`, and reads HI/LO after `Done`.

## Interface
- `W`, default 32: operand width; legal range 8..64. HI and LO are each `W` bits.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  reset, synchronous, active-low.
- `Start`  in  1  one-cycle request strobe; sampled only when `Busy`=0.
- `Op`  in  3  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MTHI, 5 MTLO
  - 6 and 7 reserved; ignored.
- `RSbus`  in  W  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- `RTbus`  in  W  rt operand: multiplier or divisor.
- `Flush`  in  1  exception cancel for the in-flight operation.
- `HI`  out  W  HI register.
- `LO`  out  W  LO register.
- `Busy`  out  1  multiply/divide in progress.
- `Done`  out  1  one-cycle pulse; HI/LO were updated by a multiply/divide on this edge.

## Operation
- State machine: IDLE, RUN, FIN.
- IDLE:
  - `Start` with Op 0..3 latches the operand magnitudes, the signedness and the result signs, loads the iteration counter with `W`, and moves to RUN.
  - `Start` with Op 4 loads HI←RSbus. `Start` with Op 5 loads LO←RSbus. Both take effect on the next edge, stay in IDLE, and do not assert `Done`.
  - Op 6/7 is ignored.
- RUN processes one bit per cycle.
  - Multiply: shift-add on unsigned magnitudes into a 2W accumulator.
  - Divide: restoring shift-subtract on unsigned magnitudes.
  - The counter decrements each cycle; at 1 the machine moves to FIN.
- FIN applies sign correction and writes HI/LO, pulses `Done`, and returns to IDLE.
- Signed ops (MULT, DIV): the magnitude of a W-bit two's-complement value is taken as a W-bit unsigned number, so −2^(W−1) has magnitude 2^(W−1).
- MULT/MULTU: {HI,LO} = the full 2W-bit product. The product is negated in FIN when exactly one operand is negative (signed op only).
- DIV/DIVU results:
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - Quotient is negated when the operand signs differ; remainder is negated when the dividend is negative.
- Divide by zero: full latency; HI = RSbus as latched, LO = all ones. This holds for both DIV and DIVU, with no sign correction.
- Signed overflow (−2^(W−1) / −1): LO = −2^(W−1), HI = 0. This falls out of the magnitude algorithm with wrapping negation.
- Operands are latched at Start. Changes on RSbus/RTbus while Busy have no effect.
- `Start` while `Busy`=1 is ignored; the controller must stall.
- `Flush`=1 in RUN or FIN: next state is IDLE, HI/LO are unchanged, and `Done` stays 0.
- `Flush` and `Start` in the same IDLE cycle: Flush wins and nothing is accepted, MTHI/MTLO included.

## Timing
- Reset (`RST_N`=0 at an edge) gives:
  - HI=0, LO=0
  - Busy=0, Done=0
  - state IDLE, counter 0
- Reset mid-operation discards all progress.
- `Busy` and `Done` are registered outputs.
- Start accepted at edge E0:
  - `Busy`=1 from E0 through the cycle before E(W+1).
  - At edge E(W+1): HI/LO update, `Done`=1, `Busy`=0.
  - `Busy` is therefore high for exactly W+1 cycles, e.g. 33 cycles for W=32.
- `Done` lasts exactly one cycle and falls at the next edge.
- Back-to-back: a `Start` asserted during the `Done` cycle (Busy=0) is accepted, giving W+1 cycles per operation with no gap.
- MTHI/MTLO: the register updates at the edge after the Start cycle, and `Busy` never rises.
- HI/LO hold their values during RUN. They change only at FIN, on MTHI/MTLO, or at reset.
- Counter width is ⌈log2(W+1)⌉ bits. All result arithmetic is modulo 2^W per register.

## Test plan
- Reset, then MULTU with RS=0xFFFFFFFF, RT=0xFFFFFFFF (W=32) -> Busy high for 33 cycles, then Done=1 with HI=0xFFFFFFFE, LO=0x00000001.
- MULT RS=−7 (0xFFFFFFF9), RT=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV cases:
  - RS=−7, RT=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - RS=0x80000000, RT=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU RS=0x12345678, RT=0 -> Done after 33 cycles, HI=0x12345678, LO=0xFFFFFFFF. Repeat with DIV and expect the same result.
- Flush and overlap:
  - Start DIVU 100/7 (after MTHI 0xAAAA and MTLO 0x5555).
  - Assert Flush on RUN cycle 10 -> IDLE next cycle, HI=0xAAAA and LO=0x5555 unchanged, no Done pulse.
  - Start pulses during Busy are ignored.
- Back-to-back and reset:
  - MULTU 3×5 with a second Start (DIVU 15/4) in its Done cycle -> HI:LO=0:15, then after 33 more cycles LO=3, HI=3.
  - Drop RST_N mid-RUN -> HI=LO=0, Busy=0.
  - Rerun MULTU 3×5 at W=8 -> Busy high 9 cycles, {HI,LO}=0x00,0x0F.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply,
// restoring divide, one bit per cycle on operand magnitudes with sign fix-up at the end.
module alu_muldiv #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         Start,
  input  logic [2:0]   Op,
  input  logic [W-1:0] RSbus,
  input  logic [W-1:0] RTbus,
  input  logic         Flush,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]   opnd_reg;
  logic [W-1:0]   rs_reg;
  logic [W-1:0]   hi_reg;
  logic [W-1:0]   lo_reg;
  logic           is_div_reg;
  logic           neg_q_reg;
  logic           neg_r_reg;
  logic           div_zero_reg;
  logic           busy_reg;
  logic           done_reg;

  logic           op_signed;
  logic           rs_neg;
  logic           rt_neg;
  logic [W-1:0]   rs_mag;
  logic [W-1:0]   rt_mag;
  logic [W:0]     sum;
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  // Magnitudes of the incoming operands; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    op_signed = (Op == 3'd0) || (Op == 3'd2);
    rs_neg    = op_signed && RSbus[W-1];
    rt_neg    = op_signed && RTbus[W-1];
    rs_mag    = rs_neg ? -RSbus : RSbus;
    rt_mag    = rt_neg ? -RTbus : RTbus;
  end

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, quotient}.
  always_comb begin
    sum     = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
    shifted = {acc_reg[2*W-1:W], acc_reg[W-1]};
    diff    = shifted - {1'b0, opnd_reg};
    if (is_div_reg) begin
      if (diff[W])
        acc_next = {shifted[W-1:0], acc_reg[W-2:0], 1'b0};
      else
        acc_next = {diff[W-1:0], acc_reg[W-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc_reg[W-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quo_fix  = neg_q_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
    rem_fix  = neg_r_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      rs_reg       <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start && !Flush) begin
            case (Op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state_reg    <= RUN;
                busy_reg     <= 1'b1;
                cnt_reg      <= CW'(W);
                is_div_reg   <= Op[1];
                neg_q_reg    <= rs_neg ^ rt_neg;
                neg_r_reg    <= rs_neg;
                div_zero_reg <= (RTbus == '0);
                rs_reg       <= RSbus;
                opnd_reg     <= Op[1] ? rt_mag : rs_mag;
                acc_reg      <= {{W{1'b0}}, (Op[1] ? rs_mag : rt_mag)};
              end
              3'd4: hi_reg <= RSbus;
              3'd5: lo_reg <= RSbus;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (Flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1))
              state_reg <= FIN;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!Flush) begin
            done_reg <= 1'b1;
            if (!is_div_reg) begin
              hi_reg <= prod_fix[2*W-1:W];
              lo_reg <= prod_fix[W-1:0];
            end else if (div_zero_reg) begin
              hi_reg <= rs_reg;
              lo_reg <= '1;
            end else begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign HI   = hi_reg;
  assign LO   = lo_reg;
  assign Busy = busy_reg;
  assign Done = done_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: W=32 instance checked through an expected-result queue,
// plus a W=8 instance for the narrow-width case.
module tb_alu_muldiv;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] RSbus;
  logic [31:0] RTbus;
  logic        Flush;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  rs8;
  logic [7:0]  rt8;
  logic        flush8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;
  logic        busy8;
  logic        done8;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  always #5 CLK = ~CLK;

  alu_muldiv #(.W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Op(Op), .RSbus(RSbus), .RTbus(RTbus),
    .Flush(Flush), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  alu_muldiv #(.W(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .Start(start8), .Op(op8), .RSbus(rs8), .RTbus(rt8),
    .Flush(flush8), .HI(hi8), .LO(lo8), .Busy(busy8), .Done(done8)
  );

  // Scoreboard: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (Done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_done: unexpected Done with HI:LO=%h:%h, required no Done", HI, LO);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({HI, LO} !== sb_exp) begin
          miscompares++;
          $display("FAIL scoreboard_result: HI:LO=%h:%h, required %h:%h",
                   HI, LO, sb_exp[63:32], sb_exp[31:0]);
        end else begin
          $display("result HI:LO=%h:%h ok", HI, LO);
        end
      end
    end
  end

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] da;
    logic signed [31:0] db;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    da = a;
    db = b;
    case (op)
      3'd0: return sa * sb;
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = da / db;
        r = da % db;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Drives one Start cycle; operands are scrambled afterwards to prove latching.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] e);
    Start = 1'b1;
    Op    = op;
    RSbus = a;
    RTbus = b;
    if (push) exp_q.push_back(e);
    $display("issue op=%0d rs=%h rt=%h", op, a, b);
    @(negedge CLK);
    Start = 1'b0;
    RSbus = $urandom;
    RTbus = $urandom;
  endtask

  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (Busy === 1'b1) busy_n++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0; RSbus = '0; RTbus = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'd0; rs8 = '0; rt8 = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    vectors++;
    if ({HI, LO} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_hilo: HI:LO=%h:%h, required 0:0", HI, LO);
    end
    vectors++;
    if ({Busy, Done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_flags: Busy,Done=%b%b, required 00", Busy, Done);
    end
    vectors++;
    if ({hi8, lo8, busy8, done8} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_w8: hi8=%h lo8=%h busy8=%b done8=%b, required all 0", hi8, lo8, busy8, done8);
    end
    $display("reset applied");
  endtask

  task automatic test_multiply;
    int  n;
    bit  seen;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    repeat (10) @(negedge CLK);
    vectors++;
    if ({HI, LO} !== 64'd0 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_hold: HI:LO=%h:%h Busy=%b, required 0:0 Busy=1", HI, LO, Busy);
    end
    wait_done(n, seen);
    vectors++;
    if (!seen || n != 23) begin
      miscompares++;
      $display("FAIL multu_latency: seen=%0d remaining busy=%0d, required seen=1 busy=23", seen, n);
    end
    @(negedge CLK);
    vectors++;
    if (Done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width: Done=%b one cycle later, required 0", Done);
    end
    issue(3'd0, 32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done(n, seen);
    vectors++;
    if (!seen || n != 33) begin
      miscompares++;
      $display("FAIL mult_latency: seen=%0d busy=%0d, required seen=1 busy=33", seen, n);
    end
  endtask

  task automatic test_divide;
    int  n;
    bit  seen;
    logic [31:0] a_tab [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] b_tab [4] = '{32'd2,         32'hFFFF_FFFF, 32'd0,         32'd0};
    logic [2:0]  o_tab [4] = '{3'd2,          3'd2,          3'd3,          3'd2};
    logic [63:0] e_tab [4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                               64'h1234_5678_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(o_tab[i], a_tab[i], b_tab[i], 1'b1, e_tab[i]);
      wait_done(n, seen);
      vectors++;
      if (!seen || n != 33) begin
        miscompares++;
        $display("FAIL div_latency[%0d]: seen=%0d busy=%0d, required seen=1 busy=33", i, seen, n);
      end
    end
  endtask

  task automatic test_flush;
    int done_n;
    issue(3'd4, 32'h0000_AAAA, 32'd0, 1'b0, 64'd0);
    vectors++;
    if (HI !== 32'h0000_AAAA || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi: HI=%h Busy=%b, required 0000aaaa Busy=0", HI, Busy);
    end
    issue(3'd5, 32'h0000_5555, 32'd0, 1'b0, 64'd0);
    vectors++;
    if (LO !== 32'h0000_5555 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo: LO=%h Busy=%b, required 00005555 Busy=0", LO, Busy);
    end
    issue(3'd6, 32'h1111_1111, 32'd0, 1'b0, 64'd0);
    vectors++;
    if ({HI, LO} !== 64'h0000_AAAA_0000_5555 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_op: HI:LO=%h:%h Busy=%b, required 0000aaaa:00005555 Busy=0", HI, LO, Busy);
    end
    issue(3'd3, 32'd100, 32'd7, 1'b0, 64'd0);
    // RUN cycle 1 now; Starts during Busy must be ignored.
    Start = 1'b1; Op = 3'd4; RSbus = 32'h1234;
    @(negedge CLK);
    Op = 3'd1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (7) @(negedge CLK);
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0 || {HI, LO} !== 64'h0000_AAAA_0000_5555) begin
      miscompares++;
      $display("FAIL flush_run: Busy=%b Done=%b HI:LO=%h:%h, required 0 0 0000aaaa:00005555",
               Busy, Done, HI, LO);
    end
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) done_n++;
      @(negedge CLK);
    end
    vectors++;
    if (done_n != 0) begin
      miscompares++;
      $display("FAIL flush_nodone: %0d Done pulses, required 0", done_n);
    end
    Flush = 1'b1; Start = 1'b1; Op = 3'd4; RSbus = 32'hDEAD;
    @(negedge CLK);
    Op = 3'd1;
    @(negedge CLK);
    Flush = 1'b0; Start = 1'b0;
    vectors++;
    if (HI !== 32'h0000_AAAA || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle: HI=%h Busy=%b, required 0000aaaa Busy=0", HI, Busy);
    end
    $display("flush scenario complete");
  endtask

  task automatic test_back_to_back;
    int n;
    bit seen;
    issue(3'd1, 32'd3, 32'd5, 1'b1, 64'd15);
    wait_done(n, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL b2b_first: Done not seen, required Done");
    end
    Start = 1'b1; Op = 3'd3; RSbus = 32'd15; RTbus = 32'd4;
    exp_q.push_back({32'd3, 32'd3});
    $display("issue op=3 rs=0000000f rt=00000004 in Done cycle");
    @(negedge CLK);
    Start = 1'b0; RSbus = $urandom; RTbus = $urandom;
    vectors++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: Busy=%b Done=%b, required 1 0", Busy, Done);
    end
    wait_done(n, seen);
    vectors++;
    if (!seen || n != 33) begin
      miscompares++;
      $display("FAIL b2b_latency: seen=%0d busy=%0d, required seen=1 busy=33", seen, n);
    end
  endtask

  task automatic test_random;
    int n;
    bit seen;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] edge_v [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h7FFF_FFFF};
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
      if (i == 0) begin op = 3'd0; a = 32'h8000_0000; b = 32'h8000_0000; end
      if (i == 1) begin op = 3'd2; a = 32'd100; b = 32'hFFFF_FFF9; end
      issue(op, a, b, 1'b1, model(op, a, b));
      wait_done(n, seen);
      vectors++;
      if (!seen || n != 33) begin
        miscompares++;
        $display("FAIL rand_latency[%0d]: seen=%0d busy=%0d, required seen=1 busy=33", i, seen, n);
      end
    end
  endtask

  task automatic test_reset_midrun;
    int done_n;
    issue(3'd0, 32'h1234, 32'h5678, 1'b0, 64'd0);
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    vectors++;
    if ({HI, LO} !== 64'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midrun: HI:LO=%h:%h Busy=%b Done=%b, required 0:0 0 0", HI, LO, Busy, Done);
    end
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) done_n++;
      @(negedge CLK);
    end
    vectors++;
    if (done_n != 0) begin
      miscompares++;
      $display("FAIL reset_nodone: %0d Done pulses, required 0", done_n);
    end
  endtask

  task automatic test_w8;
    int n;
    bit seen;
    logic [2:0]  o_tab [2] = '{3'd1, 3'd2};
    logic [7:0]  a_tab [2] = '{8'd3, 8'h80};
    logic [7:0]  b_tab [2] = '{8'd5, 8'hFF};
    logic [15:0] e_tab [2] = '{16'h000F, 16'h0080};
    for (int k = 0; k < 2; k++) begin
      start8 = 1'b1; op8 = o_tab[k]; rs8 = a_tab[k]; rt8 = b_tab[k];
      @(negedge CLK);
      start8 = 1'b0; rs8 = 8'($urandom); rt8 = 8'($urandom);
      n = 0; seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (done8 === 1'b1) begin seen = 1'b1; break; end
        if (busy8 === 1'b1) n++;
        @(negedge CLK);
      end
      vectors++;
      if (!seen || n != 9) begin
        miscompares++;
        $display("FAIL w8_latency[%0d]: seen=%0d busy=%0d, required seen=1 busy=9", k, seen, n);
      end
      vectors++;
      if ({hi8, lo8} !== e_tab[k]) begin
        miscompares++;
        $display("FAIL w8_result[%0d]: HI:LO=%h:%h, required %h:%h", k, hi8, lo8, e_tab[k][15:8], e_tab[k][7:0]);
      end else begin
        $display("w8 result HI:LO=%h:%h ok", hi8, lo8);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    test_w8();
    repeat (2) @(negedge CLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
